bidir_pio_edge: RTL and testbench



---
 rtl/bidir_pio_pkg.sv | 21 ++
 rtl/bidir_pio_edge_if.sv | 21 ++
 rtl/bidir_pio_sync.sv | 66 ++++++
 rtl/bidir_pio_edge.sv | 150 +++++++++++++++
 tb/tb_bidir_pio_edge.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bidir_pio_pkg.sv
// Shared constants for the bidirectional edge-capturing PIO:
// bus widths, register word offsets and edge-type encodings.
package bidir_pio_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned BUS_W  = 32;

    // Register word offsets
    localparam logic [ADDR_W-1:0] DATA    = 3'd0;
    localparam logic [ADDR_W-1:0] DIR     = 3'd1;
    localparam logic [ADDR_W-1:0] IRQMASK = 3'd2;
    localparam logic [ADDR_W-1:0] EDGECAP = 3'd3;
    localparam logic [ADDR_W-1:0] OUTSET  = 3'd4;
    localparam logic [ADDR_W-1:0] OUTCLR  = 3'd5;

    // EDGE_TYPE encodings
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/bidir_pio_edge_if.sv
// Chipselect/write_n slave bus used by the PIO peripherals.
interface bidir_pio_edge_if;
    import bidir_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/bidir_pio_sync.sv
// Pin input synchronizer plus one-cycle-delayed copy and edge pulse vector.
// The delayed copy and the edge pulse exist only when BIDIR_PIO_EDGE_IRQ_EN
// is defined.
module bidir_pio_sync
    import bidir_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_in,
`ifdef BIDIR_PIO_EDGE_IRQ_EN
    output logic [WIDTH-1:0] edge_pulse,
`endif
    output logic [WIDTH-1:0] sin
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("bidir_pio_sync: SYNC_STAGES must be 2..4");
    end
    if (EDGE_TYPE > EDGE_ANY) begin : g_bad_edge_type
        $error("bidir_pio_sync: EDGE_TYPE must be 0..2");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    // Metastability chain; stage 0 samples the raw pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pin_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sin = sync_q[SYNC_STAGES-1];

`ifdef BIDIR_PIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] sprev;

    // Previous synchronized value for edge comparison
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sprev <= '0;
        end else begin
            sprev <= sin;
        end
    end

    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
        assign edge_pulse = ~sin & sprev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
        assign edge_pulse = sin ^ sprev;
    end else begin : g_rise
        assign edge_pulse = sin & ~sprev;
    end
`endif

endmodule

// File: rtl/bidir_pio_edge.sv
// Memory-mapped bidirectional PIO with per-pin direction, atomic set/clear,
// synchronized input readback and optional edge capture with level irq.
// Edge capture, IRQMASK, EDGECAP and irq are built only when the macro
// BIDIR_PIO_EDGE_IRQ_EN is defined; otherwise offsets 2/3 read 0 and irq=0.
module bidir_pio_edge
    import bidir_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
    parameter logic [WIDTH-1:0] DATA_RESET  = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    bidir_pio_edge_if.slave  bus,
    inout  wire [WIDTH-1:0]  bidir_port,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("bidir_pio_edge: WIDTH must be 1..32");
    end

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] sin;
    logic [WIDTH-1:0] rd_next;
    logic             unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    // Tri-state driver per pin
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
    end

`ifdef BIDIR_PIO_EDGE_IRQ_EN
    localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned WARM_W      = $clog2(WARM_CYCLES + 1);

    logic [WIDTH-1:0]  edge_pulse;
    logic [WIDTH-1:0]  irqmask;
    logic [WIDTH-1:0]  edgecap;
    logic [WIDTH-1:0]  cap_clr;
    logic [WARM_W-1:0] warm_cnt;
    logic              warm_done;
`endif

    bidir_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .pin_in     (bidir_port),
`ifdef BIDIR_PIO_EDGE_IRQ_EN
        .edge_pulse (edge_pulse),
`endif
        .sin        (sin)
    );

    // Output data register: direct load, atomic set and atomic clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= DATA_RESET;
        end else if (wr_en) begin
            case (bus.address)
                DATA:    data_out <= wdata;
                OUTSET:  data_out <= data_out | wdata;
                OUTCLR:  data_out <= data_out & ~wdata;
                default: data_out <= data_out;
            endcase
        end
    end

    // Direction register, 1 = drive
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir <= DIR_RESET;
        end else if (wr_en && bus.address == DIR) begin
            dir <= wdata;
        end
    end

`ifdef BIDIR_PIO_EDGE_IRQ_EN
    assign warm_done = (warm_cnt == WARM_W'(WARM_CYCLES));
    assign cap_clr   = (wr_en && bus.address == EDGECAP) ? wdata : '0;

    // Warm-up: hold off edge capture until the synchronizer holds real pin data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= '0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + WARM_W'(1);
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && bus.address == IRQMASK) begin
            irqmask <= wdata;
        end
    end

    // Sticky edge capture, write-1-to-clear; a new edge beats a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~cap_clr) | (warm_done ? edge_pulse : '0);
        end
    end

    assign irq = |(edgecap & irqmask);
`else
    assign irq = 1'b0;
`endif

    // Read mux for the address currently presented
    always_comb begin
        rd_next = '0;
        case (bus.address)
            DATA:    rd_next = sin;
            DIR:     rd_next = dir;
`ifdef BIDIR_PIO_EDGE_IRQ_EN
            IRQMASK: rd_next = irqmask;
            EDGECAP: rd_next = edgecap;
`endif
            default: rd_next = '0;
        endcase
    end

    // Registered read data, refreshed every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= BUS_W'(rd_next);
        end
    end

endmodule

// File: tb/tb_bidir_pio_edge.sv
// Bench for bidir_pio_edge: three instances (rising, falling, any edge)
// share one broadcast bus and one pin stimulus; reads are checked against
// a queue of expected values filled when the stimulus is driven.
module tb_bidir_pio_edge;
    import bidir_pio_pkg::*;

`ifdef BIDIR_PIO_EDGE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam int unsigned W = 4;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] tb_pin;
    logic [W-1:0] tb_oe;

    wire  [W-1:0] pins0;
    wire  [W-1:0] pins1;
    wire  [W-1:0] pins2;
    logic [2:0]   irq_v;
    logic [2:0][31:0] rd;

    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    bidir_pio_edge_if bus0 ();
    bidir_pio_edge_if bus1 ();
    bidir_pio_edge_if bus2 ();

    assign bus0.address = address;  assign bus0.chipselect = chipselect;
    assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
    assign bus1.address = address;  assign bus1.chipselect = chipselect;
    assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
    assign bus2.address = address;  assign bus2.chipselect = chipselect;
    assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;
    assign rd = {bus2.readdata, bus1.readdata, bus0.readdata};

    for (genvar i = 0; i < W; i++) begin : g_tb_drv
        assign pins0[i] = tb_oe[i] ? tb_pin[i] : 1'bz;
        assign pins1[i] = tb_oe[i] ? tb_pin[i] : 1'bz;
        assign pins2[i] = tb_oe[i] ? tb_pin[i] : 1'bz;
    end

    bidir_pio_edge #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE),
                     .DATA_RESET(4'h0), .DIR_RESET(4'h0))
    u_rise (.clk(clk), .reset_n(reset_n), .bus(bus0), .bidir_port(pins0), .irq(irq_v[0]));

    bidir_pio_edge #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_FALL),
                     .DATA_RESET(4'h0), .DIR_RESET(4'h0))
    u_fall (.clk(clk), .reset_n(reset_n), .bus(bus1), .bidir_port(pins1), .irq(irq_v[1]));

    bidir_pio_edge #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY),
                     .DATA_RESET(4'h0), .DIR_RESET(4'h0))
    u_any (.clk(clk), .reset_n(reset_n), .bus(bus2), .bidir_port(pins2), .irq(irq_v[2]));

    function automatic logic [31:0] cap(input logic [31:0] v);
        return IRQ_ON ? v : 32'h0;
    endfunction

    function automatic void push3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [2:0][31:0] r);
        @(negedge clk);
        address = a;
        @(posedge clk); #1;
        r = rd;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0][31:0] r;
        tb_pin = '1; tb_oe = '1; reset_n = 1'b0;
        address = DATA; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        wait_cycles(3);
        for (int d = 0; d < 3; d++) begin
            chk_cnt++;
            if (rd[d] !== 32'h0 || irq_v[d] !== 1'b0)
                $display("FAIL reset_out dut%0d: readdata=%h irq=%b want 0/0", d, rd[d], irq_v[d]);
            else pass_cnt++;
        end
        @(negedge clk); reset_n = 1'b1;
        wait_cycles(8);
        push3(32'hF, 32'hF, 32'hF); bus_read(DATA, r);
        for (int d = 0; d < 3; d++) begin
            exp_v = exp_q.pop_front(); chk_cnt++;
            if (r[d] !== exp_v) $display("FAIL reset_data dut%0d: got %h want %h", d, r[d], exp_v);
            else pass_cnt++;
        end
        push3(0, 0, 0); bus_read(EDGECAP, r);
        for (int d = 0; d < 3; d++) begin
            exp_v = exp_q.pop_front(); chk_cnt++;
            if (r[d] !== exp_v) $display("FAIL reset_edgecap dut%0d: got %h want %h", d, r[d], exp_v);
            else pass_cnt++;
        end
        chk_cnt++;
        if (irq_v !== 3'b000) $display("FAIL reset_irq: got %b want 000", irq_v);
        else pass_cnt++;
    endtask

    task automatic test_output();
        logic [2:0][31:0] r;
        logic [2:0]  wa [5] = '{DATA, OUTSET, OUTCLR, DATA, OUTSET};
        logic [31:0] wd [5] = '{32'h5, 32'h2, 32'h4, 32'hFFFF_FFF0, 32'hA};
        logic [3:0]  wp [5] = '{4'h5, 4'h7, 4'h3, 4'h0, 4'hA};
        @(negedge clk); tb_oe = '0;
        bus_write(DIR, 32'hFFFF_FFFF);
        push3(32'hF, 32'hF, 32'hF); bus_read(DIR, r);
        for (int d = 0; d < 3; d++) begin
            exp_v = exp_q.pop_front(); chk_cnt++;
            if (r[d] !== exp_v) $display("FAIL dir_read dut%0d: got %h want %h", d, r[d], exp_v);
            else pass_cnt++;
        end
        for (int s = 0; s < 5; s++) begin
            push3(32'(wp[s]), 32'(wp[s]), 32'(wp[s]));
            bus_write(wa[s], wd[s]);
            for (int d = 0; d < 3; d++) begin
                logic [3:0] pv;
                pv = (d == 0) ? pins0 : (d == 1) ? pins1 : pins2;
                exp_v = exp_q.pop_front(); chk_cnt++;
                if (32'(pv) !== exp_v) $display("FAIL out_pins step%0d dut%0d: got %h want %h", s, d, pv, exp_v);
                else pass_cnt++;
            end
        end
        wait_cycles(3);
        push3(32'hA, 32'hA, 32'hA); bus_read(DATA, r);
        for (int d = 0; d < 3; d++) begin
            exp_v = exp_q.pop_front(); chk_cnt++;
            if (r[d] !== exp_v) $display("FAIL out_readback dut%0d: got %h want %h", d, r[d], exp_v);
            else pass_cnt++;
        end
        bus_write(DIR, 32'h0);
        tb_pin = '0; tb_oe = '1;
    endtask

    task automatic test_regmap();
        logic [2:0][31:0] r;
        wait_cycles(5);
        for (int a = 2; a < 8; a++) bus_write(3'(a), 32'hFFFF_FFFF);
        for (int a = 2; a < 8; a++) begin
            exp_v = (a == 2) ? cap(32'hF) : 32'h0;
            push3(exp_v, exp_v, exp_v);
            bus_read(3'(a), r);
            for (int d = 0; d < 3; d++) begin
                exp_v = exp_q.pop_front(); chk_cnt++;
                if (r[d] !== exp_v) $display("FAIL regmap_off%0d dut%0d: got %h want %h", a, d, r[d], exp_v);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (irq_v !== 3'b000) $display("FAIL regmap_irq: got %b want 000", irq_v);
        else pass_cnt++;
        bus_write(IRQMASK, 32'h0);
    endtask

    task automatic test_input_latency();
        logic [2:0] irq_exp;
        bus_write(IRQMASK, 32'h1);
        @(negedge clk); address = DATA;
        @(posedge clk); #1; tb_pin[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            exp_v = (c == 3) ? 32'h1 : 32'h0;
            push3(exp_v, exp_v, exp_v);
            for (int d = 0; d < 3; d++) begin
                exp_v = exp_q.pop_front(); chk_cnt++;
                if (rd[d] !== exp_v) $display("FAIL latency_data k+%0d dut%0d: got %h want %h", c, d, rd[d], exp_v);
                else pass_cnt++;
            end
            irq_exp = (c == 3) ? {IRQ_ON, 1'b0, IRQ_ON} : 3'b000;
            chk_cnt++;
            if (irq_v !== irq_exp) $display("FAIL latency_irq k+%0d: got %b want %b", c, irq_v, irq_exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_irq();
        logic [2:0][31:0] r;
        push3(cap(1), 0, cap(1)); bus_read(EDGECAP, r);
        for (int d = 0; d < 3; d++) begin
            exp_v = exp_q.pop_front(); chk_cnt++;
            if (r[d] !== exp_v) $display("FAIL irq_cap dut%0d: got %h want %h", d, r[d], exp_v);
            else pass_cnt++;
        end
        bus_write(EDGECAP, 32'h1);
        chk_cnt++;
        if (irq_v !== 3'b000) $display("FAIL irq_clear: got %b want 000", irq_v);
        else pass_cnt++;
        bus_write(IRQMASK, 32'h0);
        tb_pin[1] = 1'b1;
        wait_cycles(5);
        chk_cnt++;
        if (irq_v !== 3'b000) $display("FAIL irq_masked: got %b want 000", irq_v);
        else pass_cnt++;
        push3(cap(2), 0, cap(2)); bus_read(EDGECAP, r);
        for (int d = 0; d < 3; d++) begin
            exp_v = exp_q.pop_front(); chk_cnt++;
            if (r[d] !== exp_v) $display("FAIL irq_masked_cap dut%0d: got %h want %h", d, r[d], exp_v);
            else pass_cnt++;
        end
        bus_write(EDGECAP, 32'hF);
    endtask

    task automatic test_collision();
        logic [2:0][31:0] r;
        tb_pin[2] = 1'b1; wait_cycles(5);
        tb_pin[2] = 1'b0; wait_cycles(5);
        push3(cap(4), cap(4), cap(4)); bus_read(EDGECAP, r);
        for (int d = 0; d < 3; d++) begin
            exp_v = exp_q.pop_front(); chk_cnt++;
            if (r[d] !== exp_v) $display("FAIL coll_pre dut%0d: got %h want %h", d, r[d], exp_v);
            else pass_cnt++;
        end
        @(posedge clk); #1; tb_pin[2] = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        bus_write(EDGECAP, 32'h4);
        push3(cap(4), 0, cap(4)); bus_read(EDGECAP, r);
        for (int d = 0; d < 3; d++) begin
            exp_v = exp_q.pop_front(); chk_cnt++;
            if (r[d] !== exp_v) $display("FAIL coll_setwins dut%0d: got %h want %h", d, r[d], exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_modes();
        logic [2:0][31:0] r;
        for (int ph = 0; ph < 2; ph++) begin
            bus_write(EDGECAP, 32'hF);
            tb_pin[3] = (ph == 0);
            wait_cycles(5);
            if (ph == 0) push3(cap(8), 0, cap(8));
            else         push3(0, cap(8), cap(8));
            bus_read(EDGECAP, r);
            for (int d = 0; d < 3; d++) begin
                exp_v = exp_q.pop_front(); chk_cnt++;
                if (r[d] !== exp_v) $display("FAIL modes_ph%0d dut%0d: got %h want %h", ph, d, r[d], exp_v);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_midreset();
        logic [2:0][31:0] r;
        @(negedge clk); tb_oe = '0;
        bus_write(DIR, 32'hF);
        push3(32'hF, 32'hF, 32'hF); bus_read(DIR, r);
        for (int d = 0; d < 3; d++) begin
            exp_v = exp_q.pop_front(); chk_cnt++;
            if (r[d] !== exp_v) $display("FAIL midrst_pre dut%0d: got %h want %h", d, r[d], exp_v);
            else pass_cnt++;
        end
        #2; reset_n = 1'b0; #1;
        push3(0, 0, 0);
        for (int d = 0; d < 3; d++) begin
            exp_v = exp_q.pop_front(); chk_cnt++;
            if (rd[d] !== exp_v) $display("FAIL midrst_async dut%0d: got %h want %h", d, rd[d], exp_v);
            else pass_cnt++;
        end
        tb_pin = '1; tb_oe = '1;
        wait_cycles(2);
        @(negedge clk); reset_n = 1'b1;
        wait_cycles(8);
        for (int a = 0; a < 4; a++) begin
            exp_v = (a == 0) ? 32'hF : 32'h0;
            push3(exp_v, exp_v, exp_v);
            bus_read(3'(a), r);
            for (int d = 0; d < 3; d++) begin
                exp_v = exp_q.pop_front(); chk_cnt++;
                if (r[d] !== exp_v) $display("FAIL midrst_off%0d dut%0d: got %h want %h", a, d, r[d], exp_v);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_output();
        test_regmap();
        test_input_latency();
        test_irq();
        test_collision();
        test_modes();
        test_midreset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
